// File: rtl/vco_adc_multi_core.sv
// N-channel VCO-ADC back end: gated edge counters feeding a tagged result FIFO.
// Build option VCO_ADC_SAT_EN: saturating counters plus a sticky sat_flag output.
module vco_adc_multi_core #(
  parameter int N_CH       = 3,
  parameter int CNT_W      = 16,
  parameter int WIN_W      = 16,
  parameter int FIFO_DEPTH = 8,
  localparam int ID_W      = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int DW        = ID_W + CNT_W
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic [N_CH-1:0]  vco_i,
  input  logic [N_CH-1:0]  chan_en,
  input  logic [WIN_W-1:0] window_len,
  input  logic             continuous,
  input  logic             start,
  input  logic             stop,
  input  logic             rd_en,
  output logic [DW-1:0]    rd_data,
  output logic             rd_empty,
  output logic             fifo_full,
  output logic             overrun,
  input  logic             clr_ovr,
  output logic             busy,
  output logic             done
`ifdef VCO_ADC_SAT_EN
  ,
  output logic [N_CH-1:0]  sat_flag
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = ID_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DUMP
  } state_t;

  state_t state, state_n;

  logic [N_CH-1:0]  s1, s2, dly, rise;
  logic [N_CH-1:0]  en_q, m;
  logic [WIN_W-1:0] timer, timer_n;
  logic [WIN_W-1:0] reload, len_ld;
  logic [IW-1:0]    idx, idx_n;
  logic [ID_W-1:0]  sel;
  logic             hit, last;
  logic             arm, latch, count;
  logic             push, done_n;
  logic [CNT_W-1:0] cnt [N_CH];
  logic [DW-1:0]    word;

  logic [DW-1:0]    mem [FIFO_DEPTH];
  logic [AW:0]      wp, rp;
  logic             full, empty, wr, rd;

  // Two-flop synchroniser, then one more flop for rising-edge detect
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      s1  <= '0;
      s2  <= '0;
      dly <= '0;
    end else begin
      s1  <= vco_i;
      s2  <= s1;
      dly <= s2;
    end
  end

  assign rise = s2 & ~dly;

  assign len_ld = (window_len == '0) ? '0 : window_len - 1'b1;

  // Next enabled channel at or above idx, and whether it is the final one
  always_comb begin
    m    = '0;
    sel  = '0;
    hit  = 1'b0;
    last = 1'b1;
    for (int i = 0; i < N_CH; i++)
      m[i] = en_q[i] && (i >= int'(idx));
    for (int i = 0; i < N_CH; i++)
      if (m[i] && !hit) begin
        sel = ID_W'(i);
        hit = 1'b1;
      end
    for (int i = 0; i < N_CH; i++)
      if (m[i] && (i > int'(sel)))
        last = 1'b0;
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    idx_n   = idx;
    arm     = 1'b0;
    latch   = 1'b0;
    count   = 1'b0;
    push    = 1'b0;
    done_n  = 1'b0;
    if (stop) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            latch   = 1'b1;
            arm     = 1'b1;
            timer_n = len_ld;
            state_n = COUNT;
          end
        end
        COUNT: begin
          count = 1'b1;
          if (timer == '0) begin
            idx_n   = '0;
            state_n = DUMP;
          end else begin
            timer_n = timer - 1'b1;
          end
        end
        DUMP: begin
          push  = hit;
          idx_n = IW'(sel) + IW'(1);
          if (last) begin
            if (continuous) begin
              arm     = 1'b1;
              timer_n = reload;
              state_n = COUNT;
            end else begin
              done_n  = 1'b1;
              state_n = IDLE;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state  <= IDLE;
      timer  <= '0;
      idx    <= '0;
      en_q   <= '0;
      reload <= '0;
      done   <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      idx   <= idx_n;
      done  <= done_n;
      if (latch) begin
        en_q   <= chan_en;
        reload <= len_ld;
      end
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < N_CH; i++)
        cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (arm) begin
          cnt[i] <= '0;
        end else if (count && en_q[i] && rise[i]) begin
`ifdef VCO_ADC_SAT_EN
          if (cnt[i] != '1)
            cnt[i] <= cnt[i] + 1'b1;
`else
          cnt[i] <= cnt[i] + 1'b1;
`endif
        end
      end
    end
  end

`ifdef VCO_ADC_SAT_EN
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sat_flag <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (arm)
          sat_flag[i] <= 1'b0;
        else if (count && en_q[i] && rise[i] && (cnt[i] == '1))
          sat_flag[i] <= 1'b1;
      end
    end
  end
`endif

  assign word  = {sel, cnt[sel]};
  assign busy  = (state != IDLE);

  assign empty = (wp == rp);
  assign full  = ((wp ^ rp) == {1'b1, {AW{1'b0}}});
  assign wr    = push && (!full || rd_en);
  assign rd    = rd_en && !empty;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      wp      <= '0;
      rp      <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr)
        wp <= wp + 1'b1;
      if (rd)
        rp <= rp + 1'b1;
      if (push && full && !rd_en)
        overrun <= 1'b1;
      else if (clr_ovr)
        overrun <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (wr)
      mem[wp[AW-1:0]] <= word;
  end

  assign rd_data   = empty ? '0 : mem[rp[AW-1:0]];
  assign rd_empty  = empty;
  assign fifo_full = full;

endmodule

// File: tb/tb_vco_adc_multi_core.sv
// Randomised scoreboard bench for vco_adc_multi_core.
// Words are predicted from edge history; a monitor checks every FIFO pop.
module tb_vco_adc_multi_core;

  localparam int N_CH       = 3;
  localparam int CNT_W      = 5;
  localparam int WIN_W      = 16;
  localparam int FIFO_DEPTH = 8;
  localparam int ID_W       = 2;
  localparam int DW         = ID_W + CNT_W;
  localparam int CMAX       = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             resetb = 1'b0;
  logic [N_CH-1:0]  vco_i = '0;
  logic [N_CH-1:0]  chan_en = '0;
  logic [WIN_W-1:0] window_len = '0;
  logic             continuous = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             rd_en = 1'b0;
  logic             clr_ovr = 1'b0;
  logic [DW-1:0]    rd_data;
  logic             rd_empty, fifo_full, overrun, busy, done;
`ifdef VCO_ADC_SAT_EN
  logic [N_CH-1:0]  sat_flag;
`endif

  vco_adc_multi_core #(
    .N_CH(N_CH), .CNT_W(CNT_W), .WIN_W(WIN_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clock(clock), .resetb(resetb), .vco_i(vco_i), .chan_en(chan_en),
    .window_len(window_len), .continuous(continuous), .start(start),
    .stop(stop), .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty),
    .fifo_full(fifo_full), .overrun(overrun), .clr_ovr(clr_ovr),
    .busy(busy), .done(done)
`ifdef VCO_ADC_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int n = 0;
  int occ = 0;
  bit ovr = 1'b0;
  int busy_lo = 0;
  int busy_hi = 0;
  int done_at = -1;
  logic [DW-1:0]   sbq[$];
  logic [DW-1:0]   push_word[int];
  logic [N_CH-1:0] vh[int];
  logic [N_CH-1:0] exp_sat = '0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, n);
    end
  endtask

  always @(negedge clock) begin
    if (resetb && rd_en && !rd_empty) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_data: unexpected word %0h, nothing expected", rd_data);
      end else begin
        chk("rd_data", rd_data, sbq.pop_front());
      end
    end
  end

  task automatic setv();
    logic [N_CH-1:0] pv;
    if (!vh.exists(n)) begin
      pv = vh.exists(n - 1) ? vh[n - 1] : '0;
      for (int i = 0; i < N_CH; i++)
        if ($urandom_range(0, 99) < 30) pv[i] = ~pv[i];
      vh[n] = pv;
    end
    vco_i = vh[n];
  endtask

  task automatic tick();
    int p;
    bit rdp;
    bit nov;
    @(posedge clock);
    #1;
    p   = n;
    rdp = rd_en && (occ > 0);
    nov = 1'b0;
    if (push_word.exists(p)) begin
      if (occ < FIFO_DEPTH || rd_en) begin
        sbq.push_back(push_word[p]);
        occ++;
      end else begin
        nov = 1'b1;
      end
      push_word.delete(p);
    end
    if (rdp) occ--;
    if (nov) ovr = 1'b1;
    else if (clr_ovr) ovr = 1'b0;
    n++;
    chk("busy", busy, (p >= busy_lo && p < busy_hi));
    chk("done", done, (p == done_at));
    chk("fifo_full", fifo_full, (occ == FIFO_DEPTH));
    chk("rd_empty", rd_empty, (occ == 0));
    chk("overrun", overrun, ovr);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      start = 0; stop = 0; rd_en = 0; clr_ovr = 0;
      setv();
      tick();
    end
  endtask

  task automatic drain();
    for (int k = 0; k < FIFO_DEPTH + 4 && occ > 0; k++) begin
      rd_en = 1'b1;
      setv();
      tick();
    end
    rd_en = 1'b0;
    chk("drained", rd_empty, 1);
  endtask

  task automatic conv(input logic [N_CH-1:0] en, input int len, input int nwin,
                      input int stop_at, input int rd_pct, input int mode,
                      input int rst_at);
    int S, L, D, P, E, W, j, c, v, lastp;
    int per[3];
    int prob[N_CH];
    logic [N_CH-1:0] nv;
    per = '{2, 4, 10};
    S = n;
    L = (len == 0) ? 1 : len;
    D = $countones(en);
    if (D == 0) D = 1;
    P = L + D;
    E = (stop_at > 0) ? S + stop_at : S + nwin * P;
    for (int i = 0; i < N_CH; i++) prob[i] = $urandom_range(5, 95);
    for (int k = S; k <= E + 2; k++) begin
      nv = vh[k - 1];
      for (int i = 0; i < N_CH; i++) begin
        if (mode == 1) nv[i] = (((k - S) / per[i]) % 2) != 0;
        else if (mode == 2) nv[i] = ~nv[i];
        else if ($urandom_range(0, 99) < prob[i]) nv[i] = ~nv[i];
      end
      vh[k] = nv;
    end
    if (stop_at == 0) begin
      for (int w = 0; w < nwin; w++) begin
        W = S + w * P;
        j = 0;
        if (w == nwin - 1) exp_sat = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
          if (en[ch]) begin
            c = 0;
            for (int k = W - 1; k <= W + L - 2; k++)
              if (vh[k][ch] && !vh[k - 1][ch]) c++;
`ifdef VCO_ADC_SAT_EN
            v = (c > CMAX) ? CMAX : c;
            if (w == nwin - 1) exp_sat[ch] = (c > CMAX);
`else
            v = c % (CMAX + 1);
`endif
            push_word[W + L + 1 + j] = {ID_W'(ch), CNT_W'(v)};
            j++;
          end
        end
      end
    end
    busy_lo = S;
    busy_hi = E;
    done_at = (stop_at > 0) ? -1 : E;
    lastp = (rst_at > 0) ? S + rst_at - 1 : E;
    for (int p = S; p <= lastp; p++) begin
      start = (p == S) || (p > S && p < E && $urandom_range(0, 9) == 0);
      stop = (stop_at > 0) && (p == S + stop_at);
      continuous = (nwin > 1) && (p <= S + (nwin - 1) * P);
      chan_en = (p == S) ? en : N_CH'($urandom);
      window_len = (p == S) ? WIN_W'(len) : WIN_W'($urandom_range(0, 200));
      if (rd_pct < 0) rd_en = push_word.exists(p);
      else rd_en = ($urandom_range(0, 99) < rd_pct);
      clr_ovr = 1'b0;
      setv();
      tick();
    end
    start = 0; stop = 0; continuous = 0; rd_en = 0;
    if (rst_at > 0) begin
      resetb = 1'b0;
      #1;
      chk("rst rd_empty", rd_empty, 1);
      chk("rst busy", busy, 0);
      chk("rst fifo_full", fifo_full, 0);
      chk("rst overrun", overrun, 0);
      chk("rst done", done, 0);
      chk("rst rd_data", rd_data, 0);
`ifdef VCO_ADC_SAT_EN
      chk("rst sat_flag", sat_flag, 0);
`endif
      occ = 0; ovr = 1'b0; busy_hi = 0; done_at = -1; exp_sat = '0;
      sbq.delete();
      push_word.delete();
      idle(2);
      resetb = 1'b1;
    end else if (stop_at == 0) begin
`ifdef VCO_ADC_SAT_EN
      chk("sat_flag", sat_flag, exp_sat);
`endif
    end
  endtask

  initial begin
    logic [N_CH-1:0] ren;
    int rlen, rwin, rst, rrd, rl;
    resetb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      setv();
      tick();
    end
    chk("reset rd_data", rd_data, 0);
`ifdef VCO_ADC_SAT_EN
    chk("reset sat_flag", sat_flag, 0);
`endif
    resetb = 1'b1;
    idle(5);

    conv(3'b111, 100, 1, 0, 0, 1, 0);
    drain();
    conv(3'b001, 0, 1, 0, 50, 0, 0);
    drain();

    conv(3'b111, 6, 3, 0, 0, 0, 0);
    chk("overrun after 9 pushes", overrun, 1);
    clr_ovr = 1'b1;
    setv();
    tick();
    clr_ovr = 1'b0;
    chk("overrun cleared", overrun, 0);

    conv(3'b111, 8, 1, 0, -1, 0, 0);
    chk("no overrun with rd_en", overrun, 0);
    drain();

    conv(3'b000, 4, 1, 0, 0, 0, 0);
    conv(3'b111, 20, 1, 7, 0, 0, 0);
    conv(3'b101, 10, 1, 0, 30, 0, 0);
    drain();
    conv(3'b111, 90, 1, 0, 20, 2, 0);
    drain();

    for (int t = 0; t < 15; t++) begin
      ren  = N_CH'($urandom);
      rlen = $urandom_range(0, 40);
      rwin = $urandom_range(1, 3);
      rst  = 0;
      if ($urandom_range(0, 4) == 0) begin
        rwin = 1;
        rl   = (rlen == 0) ? 1 : rlen;
        rst  = $urandom_range(1, rl);
      end
      rrd = $urandom_range(0, 100);
      conv(ren, rlen, rwin, rst, rrd, 0, 0);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 3));
    end
    drain();
    clr_ovr = 1'b1;
    setv();
    tick();
    clr_ovr = 1'b0;

    conv(3'b111, 5, 1, 0, 0, 0, 7);
    idle(5);
    conv(3'b011, 12, 2, 0, 40, 0, 0);
    drain();
    chk("scoreboard empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
